// File: rtl/ecp5pll_phase_ctl.sv
// Timed phase-step sequencer for the ECP5 PLL dynamic phase port; accept->DONE = 1+S+N(P+H)+(N-1)G+L(P+H) cycles.
// Requests are held off (req_ready=0) while busy or unlocked; optional position tracking via `ECP5PLL_PHASE_CTL_POS_TRACK_EN.
module ecp5pll_phase_ctl #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 4,
  parameter int COUNT_W   = 8,
  parameter int POS_W     = 10
) (
  input  logic                 clk_i,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_sel,
  input  logic                 req_dir,
  input  logic [COUNT_W-1:0]   req_count,
  input  logic                 req_load,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 pll_locked,
  output logic [1:0]           phasesel,
  output logic                 phasedir,
  output logic                 phasestep,
  output logic                 phaseloadreg,
  output logic [4*POS_W-1:0]   pos_o
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_SP > MAX_HG) ? MAX_SP : MAX_HG;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, STEP, HOLD, GAP, LOAD, LHOLD, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 load_q, load_d;
  logic                 abort_q, abort_d;
  logic [1:0]           sel_q, sel_d;
  logic                 dir_q, dir_d;
  logic                 step_q, step_d;
  logic                 ldreg_q, ldreg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic accept, tmr_done, step_exit, abort_now;

  assign req_ready = (state_q == IDLE) && pll_locked && reset_n;
  assign accept    = req_valid && req_ready;
  assign tmr_done  = (tmr_q == '0);
  assign step_exit = (state_q == STEP) && tmr_done;
  // Lock loss seen now or earlier in this pulse/hold both end the sequence after the hold.
  assign abort_now = abort_q || !pll_locked;

  function automatic logic [TW-1:0] dur(state_t s);
    case (s)
      SETUP:       dur = TW'(SETUP_CYC - 1);
      STEP, LOAD:  dur = TW'(PULSE_CYC - 1);
      HOLD, LHOLD: dur = TW'(HOLD_CYC - 1);
      GAP:         dur = TW'(GAP_CYC - 1);
      default:     dur = '0;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = (req_count == '0 && !req_load) ? DONE : SETUP;
      SETUP: if (!pll_locked)  state_d = IDLE;
             else if (tmr_done) state_d = (cnt_q != '0) ? STEP : LOAD;
      STEP:  if (tmr_done) state_d = HOLD;
      HOLD:  if (tmr_done) begin
               if (abort_now)          state_d = IDLE;
               else if (cnt_q != '0)   state_d = GAP;
               else if (load_q)        state_d = LOAD;
               else                    state_d = DONE;
             end
      GAP:   if (!pll_locked)  state_d = IDLE;
             else if (tmr_done) state_d = STEP;
      LOAD:  if (tmr_done) state_d = LHOLD;
      LHOLD: if (tmr_done) state_d = abort_now ? IDLE : DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tmr_d   = (state_d != state_q) ? dur(state_d) : tmr_q - TW'(1);
    cnt_d   = cnt_q;
    load_d  = load_q;
    abort_d = abort_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d   = req_count;
      load_d  = req_load;
      abort_d = 1'b0;
      sel_d   = req_sel;
      dir_d   = req_dir;
      err_d   = 1'b0;
    end else begin
      if (step_exit) cnt_d = cnt_q - COUNT_W'(1);
      if (!pll_locked && (state_q == STEP || state_q == HOLD ||
                          state_q == LOAD || state_q == LHOLD))
        abort_d = 1'b1;
      if (state_q != IDLE && state_q != DONE && state_d == IDLE)
        err_d = 1'b1;
    end
    step_d  = (state_d == STEP);
    ldreg_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      tmr_q   <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      abort_q <= 1'b0;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      ldreg_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      abort_q <= abort_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      ldreg_q <= ldreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = step_q;
  assign phaseloadreg = ldreg_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

`ifdef ECP5PLL_PHASE_CTL_POS_TRACK_EN
  logic [3:0][POS_W-1:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (step_exit)
      pos_d[sel_q] = dir_q ? pos_q[sel_q] - POS_W'(1) : pos_q[sel_q] + POS_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) pos_q <= '0;
    else          pos_q <= pos_d;
  end

  assign pos_o = pos_q;
`else
  assign pos_o = '0;
`endif

endmodule

// File: tb/tb_ecp5pll_phase_ctl.sv
// Randomized bench for ecp5pll_phase_ctl: expected waveforms come from the closed-form timing rules per request,
// plus lock-loss aborts, reset mid-sequence and position wrap.
`timescale 1ns/1ps
module tb_ecp5pll_phase_ctl;
  localparam int S  = 2;
  localparam int P  = 4;
  localparam int H  = 2;
  localparam int G  = 4;
  localparam int CW = 8;
  localparam int PW = 4;

  logic            clk_i = 1'b0;
  logic            reset_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_dir = 1'b0;
  logic            req_load = 1'b0;
  logic            pll_locked = 1'b0;
  logic [1:0]      req_sel = '0;
  logic [CW-1:0]   req_count = '0;
  logic            req_ready, busy, done, err, phasedir, phasestep, phaseloadreg;
  logic [1:0]      phasesel;
  logic [4*PW-1:0] pos_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pos_m [4];

  always #5 clk_i = ~clk_i;

  ecp5pll_phase_ctl #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .GAP_CYC(G), .COUNT_W(CW), .POS_W(PW)
  ) dut (
    .clk_i(clk_i), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_dir(req_dir),
    .req_count(req_count), .req_load(req_load),
    .busy(busy), .done(done), .err(err), .pll_locked(pll_locked),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg),
    .pos_o(pos_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  function automatic logic [8:0] obs();
    return {busy, done, err, phasestep, phaseloadreg, phasesel, phasedir, req_ready};
  endfunction

  function automatic int done_at(input int n, input bit ld);
    if (n > 0) return 1 + S + n*(P+H) + (n-1)*G + (ld ? P+H : 0);
    if (ld)    return 1 + S + P + H;
    return 1;
  endfunction

  // Expected outputs k cycles after acceptance of an uninterrupted request.
  function automatic logic [8:0] exp_vec(input int k, input logic [1:0] sel, input bit dir,
                                         input int n, input bit ld);
    int d, ls;
    bit st, lr;
    d  = done_at(n, ld);
    st = 1'b0;
    for (int i = 0; i < n; i++)
      if (k >= 1+S+i*(P+H+G) && k < 1+S+i*(P+H+G)+P) st = 1'b1;
    ls = (n > 0) ? 1+S+n*(P+H)+(n-1)*G : 1+S;
    lr = ld && k >= ls && k < ls+P;
    return {k <= d, k == d, 1'b0, st, lr, sel, dir, k > d};
  endfunction

  function automatic logic [4*PW-1:0] exp_pos();
    logic [4*PW-1:0] v;
    v = '0;
`ifdef ECP5PLL_PHASE_CTL_POS_TRACK_EN
    for (int c = 0; c < 4; c++) v[c*PW +: PW] = PW'(pos_m[c]);
`endif
    return v;
  endfunction

  task automatic accept_req(input logic [1:0] sel, input bit dir, input int n, input bit ld,
                            input string tag);
    int w;
    w = 0;
    while (!req_ready && w < 100) begin
      tick();
      w++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_sel   = sel;
    req_dir   = dir;
    req_count = CW'(n);
    req_load  = ld;
  endtask

  task automatic garbage(input bit vld);
    req_valid = vld;
    req_sel   = 2'($urandom);
    req_dir   = 1'($urandom);
    req_count = CW'($urandom);
    req_load  = 1'($urandom);
  endtask

  task automatic run_req(input logic [1:0] sel, input bit dir, input int n, input bit ld,
                         input string tag);
    int d;
    accept_req(sel, dir, n, ld, tag);
    d = done_at(n, ld);
    for (int k = 1; k <= d+1; k++) begin
      tick();
      check({tag, "_vec"}, 32'(obs()), 32'(exp_vec(k, sel, dir, n, ld)));
      garbage(k <= d);
    end
    pos_m[sel] += dir ? -n : n;
    check({tag, "_pos"}, 32'(pos_o), 32'(exp_pos()));
  endtask

  // Lock drops during cycle drop_k; exactly one step pulse is expected, idle with err from busy_to+1.
  task automatic abort_run(input logic [1:0] sel, input bit dir, input int n, input bit ld,
                           input int drop_k, input int busy_to, input string tag);
    logic [8:0] e;
    accept_req(sel, dir, n, ld, tag);
    for (int k = 1; k <= busy_to+8; k++) begin
      tick();
      e = {k <= busy_to, 1'b0, k > busy_to, (k >= 1+S && k < 1+S+P), 1'b0, sel, dir, 1'b0};
      check({tag, "_vec"}, 32'(obs()), 32'(e));
      if (k == drop_k) pll_locked = 1'b0;
      garbage(1'b1);
    end
    pos_m[sel] += dir ? -1 : 1;
    pll_locked = 1'b1;
    req_valid  = 1'b1;
    req_sel    = 2'd0;
    req_dir    = 1'b0;
    req_count  = '0;
    req_load   = 1'b0;
    tick();
    check({tag, "_reaccept"}, 32'(obs()), 32'(9'b1_1000_0000));
    req_valid = 1'b0;
    tick();
    check({tag, "_idle"}, 32'(obs()), 32'(9'b0_0000_0001));
    check({tag, "_pos"}, 32'(pos_o), 32'(exp_pos()));
  endtask

  initial begin
    for (int c = 0; c < 4; c++) pos_m[c] = 0;
    pll_locked = 1'b1;
    repeat (3) tick();
    check("reset_vec", 32'(obs()), 32'd0);
    check("reset_pos", 32'(pos_o), 32'd0);
    reset_n = 1'b1;
    tick();
    check("ready_locked", 32'(req_ready), 32'd1);
    pll_locked = 1'b0;
    #1;
    check("ready_unlocked", 32'(req_ready), 32'd0);
    pll_locked = 1'b1;
    tick();

    run_req(2'd0, 1'b1, 1, 1'b0, "wrap");
    run_req(2'd2, 1'b0, 3, 1'b0, "n3");
    run_req(2'd1, 1'b1, 0, 1'b1, "load_only");
    run_req(2'd3, 1'b0, 0, 1'b0, "zero");
    run_req(2'd1, 1'b0, 2, 1'b1, "n2_load");

    for (int r = 0; r < 40; r++) begin
      run_req(2'($urandom), 1'($urandom), int'($urandom_range(5, 0)), 1'($urandom), "rand");
      repeat ($urandom_range(2, 0)) tick();
    end

    abort_run(2'd1, 1'b0, 5, 1'b0, 10, 10, "gap_abort");
    abort_run(2'd3, 1'b1, 3, 1'b1, 4, 8, "step_abort");

    accept_req(2'd2, 1'b0, 2, 1'b0, "rst");
    for (int k = 1; k <= 4; k++) begin
      tick();
      garbage(1'b0);
    end
    check("rst_in_step", 32'(phasestep), 32'd1);
    reset_n = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) pos_m[c] = 0;
    check("rst_vec", 32'(obs()), 32'd0);
    check("rst_pos", 32'(pos_o), 32'(exp_pos()));
    tick();
    reset_n = 1'b1;
    tick();
    run_req(2'd0, 1'b1, 1, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
